jtag_host_driver: RTL
=====================

Name: jtag_host_driver

Overview:
- Host-side initiator for the uP's JTAG(esque) port. It drives TCK/TMS/TDI and captures TDO.
- Used by test/bring-up harnesses and by a future debug-bridge FPGA to talk to the JtagPort responder.
- Turns one command (1..32 bits, LSB first, with a TMS profile) into a slowed-down TCK bit sequence and returns the captured TDO word.
- TCK is divided from the system clock, so the responder's two-flop input synchronizers always see clean edges.

Parameters:
- HALF_PERIOD, 4, i_clk cycles per TCK phase (low and high). Legal range 4..255. 4 is the minimum that covers responder sync plus register latency.
- SYNC_TDO, 1, when 1, i_jtagTDO passes through a 2-flop synchronizer before sampling. When 0, it is sampled directly.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cmdValid  in  1  command request
- o_cmdReady  out  1  command accept; a transfer occurs when valid & ready
- i_cmdLen  in  5  bit count minus one (0 = 1 bit, 31 = 32 bits)
- i_cmdData  in  32  TDI bits, bit 0 shifted first
- i_cmdTms  in  1  TMS value for every bit except the last
- i_cmdTmsLast  in  1  TMS value for the last bit
- o_rspValid  out  1  captured TDO word available
- i_rspReady  in  1  response accept
- o_rspData  out  32  captured TDO bits, bit 0 = first captured
- o_jtagTCK  out  1  to uP i_jtagTCK
- o_jtagTMS  out  1  to uP i_jtagTMS
- o_jtagTDI  out  1  to uP i_jtagTDI
- i_jtagTDO  in  1  from uP o_jtagTDO
- o_busy  out  1  high in LOW/HIGH/DONE

Behaviour:
- Reset values: o_jtagTCK=0, o_jtagTMS=1, o_jtagTDI=0, o_cmdReady=0 while i_rst is high, o_rspValid=0, o_rspData=0, o_busy=0. State returns to IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: o_cmdReady=1. On valid&ready, latch len/data/tms/tmsLast, clear the capture register and bit index, and go to LOW.
  - LOW (HALF_PERIOD cycles): TCK=0; TMS/TDI present bit[idx]. TMS is tmsLast when idx==len, else tms.
  - HIGH (HALF_PERIOD cycles): TCK=1; TMS/TDI are held.
    - On the last HIGH cycle, sample TDO (synchronized if SYNC_TDO) into rspData[idx].
    - If idx==len, go to DONE; else idx+1 and go to LOW.
  - DONE: TCK=0; o_rspValid=1; TMS/TDI hold their last values. On i_rspReady, go to IDLE.
- Latency: accept on cycle 0 gives o_rspValid high on cycle 2*HALF_PERIOD*(len+1)+1.
- Response hold: o_rspValid holds until accepted, with rspData stable. No new command is accepted while DONE (backpressure).
- Between commands, TMS/TDI keep their last driven values and TCK stays 0.
- Bit positions above len in rspData are 0.
- The phase counter is ceil(log2(HALF_PERIOD)) bits wide. It reloads on every phase change and never wraps mid-phase.
- i_cmdValid during LOW/HIGH/DONE is ignored (ready=0). The command must be held by the source.
- i_rst mid-operation: immediate return to the reset values. A partial TCK high pulse is truncated; no response is produced.
- The first cycle after reset deassertion is IDLE with ready=1.

Decomposition:
- Shared package, jtag_host_pkg:
  - state enum {IDLE, LOW, HIGH, DONE}
  - JTAG_MAX_BITS=32
  - JTAG_LEN_W=5
  - JTAG_MIN_HALF=4 (elaboration-time assertion on HALF_PERIOD)
- One sub-module: tdo_synchronizer, a 2-flop synchronizer with async active-high reset to 0. It is instantiated only when SYNC_TDO=1.

Test Plan:
1. Reset, then 1-bit cmd (len=0, data=1, tms=0, tmsLast=1), HALF_PERIOD=4 -> TCK high on cycles 5-8; TMS=1 and TDI=1 from cycle 1; rspValid at cycle 9.
2. Loopback TDO=TDI (SYNC_TDO=1); 8-bit cmd data=0xA5 -> TDI sequence 1,0,1,0,0,1,0,1; rspData=0x000000A5 at cycle 65.
3. 32-bit cmd data=0xDEADBEEF, TDO tied to 1 -> rspData=0xFFFFFFFF. Exactly 32 TCK rising edges. TMS=tms for 31 bits, then tmsLast.
4. Backpressure: hold i_rspReady=0 for 20 cycles after rspValid, with a second cmd pending -> rspValid and data stable, cmdReady=0. Ready pulse -> IDLE; second cmd accepted next cycle.
5. Assert i_rst during HIGH of bit 3 of a 16-bit cmd -> same cycle: TCK=0, TMS=1, TDI=0, busy=0; no rspValid afterwards.
6. tms=1, tmsLast=0, len=4 against the uP JtagPort model -> TMS sequence 1,1,1,1,0 observed at the 5 TCK rising edges.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and constants for the JTAG host driver.
package jtag_host_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam int JTAG_MAX_BITS = 32;
  localparam int JTAG_LEN_W    = 5;
  localparam int JTAG_MIN_HALF = 4;

  // The last bit of a command carries its own TMS value so a shift can exit in one go.
  function automatic logic tms_for_bit(input logic [JTAG_LEN_W-1:0] idx,
                                       input logic [JTAG_LEN_W-1:0] len,
                                       input logic tms, input logic tms_last);
    return (idx == len) ? tms_last : tms;
  endfunction
endpackage

// File: rtl/jtag_host_if.sv
// Command/response handshake bundle between a harness and the JTAG host driver.
interface jtag_host_if;
  logic                                  i_cmdValid;
  logic                                  o_cmdReady;
  logic [jtag_host_pkg::JTAG_LEN_W-1:0]  i_cmdLen;
  logic [jtag_host_pkg::JTAG_MAX_BITS-1:0] i_cmdData;
  logic                                  i_cmdTms;
  logic                                  i_cmdTmsLast;
  logic                                  o_rspValid;
  logic                                  i_rspReady;
  logic [jtag_host_pkg::JTAG_MAX_BITS-1:0] o_rspData;

  modport master (
    output i_cmdValid, i_cmdLen, i_cmdData, i_cmdTms, i_cmdTmsLast, i_rspReady,
    input  o_cmdReady, o_rspValid, o_rspData
  );

  modport slave (
    input  i_cmdValid, i_cmdLen, i_cmdData, i_cmdTms, i_cmdTmsLast, i_rspReady,
    output o_cmdReady, o_rspValid, o_rspData
  );
endinterface

// File: rtl/jtag_host_driver_tdo_sync.sv
// Two-flop synchronizer bringing the responder's TDO into the system clock domain.
module tdo_synchronizer (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/jtag_host_driver.sv
// Host-side JTAG initiator: shifts one 1..32 bit command out on a divided TCK and returns captured TDO.
module jtag_host_driver
  import jtag_host_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter bit SYNC_TDO    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  jtag_host_if.slave  host,
  output logic        o_jtagTCK,
  output logic        o_jtagTMS,
  output logic        o_jtagTDI,
  input  logic        i_jtagTDO,
  output logic        o_busy
);
  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_PERIOD - 1);

  if (HALF_PERIOD < JTAG_MIN_HALF || HALF_PERIOD > 255) begin : g_bad_half
    $error("jtag_host_driver: HALF_PERIOD must be within 4..255");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [JTAG_LEN_W-1:0]    idx_q, idx_d, idx_n, len_q, len_d;
  logic [JTAG_MAX_BITS-1:0] data_q, data_d, rsp_q, rsp_d;
  logic tms_q, tms_d, tms_last_q, tms_last_d;
  logic tck_q, tck_d, tms_out_q, tms_out_d, tdi_q, tdi_d;
  logic ready_q, ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic tdo_s, phase_end;

  if (SYNC_TDO) begin : g_sync
    tdo_synchronizer u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_jtagTDO), .o_q(tdo_s));
  end else begin : g_direct
    assign tdo_s = i_jtagTDO;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    idx_n      = idx_q + JTAG_LEN_W'(1);
    len_d      = len_q;
    data_d     = data_q;
    rsp_d      = rsp_q;
    tms_d      = tms_q;
    tms_last_d = tms_last_q;
    tms_out_d  = tms_out_q;
    tdi_d      = tdi_q;
    phase_end  = (cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (ready_q && host.i_cmdValid) begin
          len_d      = host.i_cmdLen;
          data_d     = host.i_cmdData;
          tms_d      = host.i_cmdTms;
          tms_last_d = host.i_cmdTmsLast;
          rsp_d      = '0;
          idx_d      = '0;
          cnt_d      = CNT_LOAD;
          tdi_d      = host.i_cmdData[0];
          tms_out_d  = tms_for_bit('0, host.i_cmdLen, host.i_cmdTms, host.i_cmdTmsLast);
          state_d    = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          cnt_d   = CNT_LOAD;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          rsp_d[idx_q] = tdo_s;
          if (idx_q == len_q) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_n;
            cnt_d     = CNT_LOAD;
            tdi_d     = data_q[idx_n];
            tms_out_d = tms_for_bit(idx_n, len_q, tms_q, tms_last_q);
            state_d   = LOW;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (host.i_rspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    tck_d       = (state_d == HIGH);
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rsp_q       <= '0;
      tck_q       <= 1'b0;
      tms_out_q   <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rsp_q       <= rsp_d;
      tck_q       <= tck_d;
      tms_out_q   <= tms_out_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Command payload is only consumed after acceptance, so it needs no reset.
  always_ff @(posedge i_clk) begin
    len_q      <= len_d;
    data_q     <= data_d;
    tms_q      <= tms_d;
    tms_last_q <= tms_last_d;
  end

  assign host.o_cmdReady = ready_q;
  assign host.o_rspValid = rsp_valid_q;
  assign host.o_rspData  = rsp_q;
  assign o_jtagTCK       = tck_q;
  assign o_jtagTMS       = tms_out_q;
  assign o_jtagTDI       = tdi_q;
  assign o_busy          = busy_q;
endmodule
